// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers, used by both the write-side and read-side controllers.
// Functions work on a fixed wide vector; callers zero-extend in and truncate out.
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = gray;
        for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
// Pure flop chain, reset to zero; no logic between stages.
module gray_sync #(
    parameter int unsigned Width  = 4,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer controller of an async FIFO: pointers, full/almost-full, level and
// a sticky overflow flag, all computed against the synchronized Gray read pointer.
module wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   g_rd_ptr_async,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic              clr_ovf,
    output logic              wr_push,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   b_wr_ptr,
    output logic [ADDR_W:0]   g_wr_ptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    localparam int unsigned PtrW = ADDR_W + 1;

    logic [PtrW-1:0] b_q, b_d;
    logic [PtrW-1:0] g_q, g_d;
    logic [PtrW-1:0] level_q, level_d;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ovf_q, ovf_d;
    logic [PtrW-1:0] rq;
    logic [PtrW-1:0] b_rq;
    logic [PtrW-1:0] rq_full_pattern;

    gray_sync #(
        .Width  (PtrW),
        .Stages (SYNC_STAGES)
    ) u_rd_sync (
        .clk_i (wr_clk),
        .rst_i (wr_rst),
        .d_i   (g_rd_ptr_async),
        .q_o   (rq)
    );

    // Gated by reset so a push held during reset never strobes the RAM.
    assign wr_push = wr_en && !full_q && !wr_rst;

    // Full when the write pointer laps the read pointer: top two Gray bits inverted.
    assign rq_full_pattern = {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]};

    always_comb begin
        b_d     = b_q + {{ADDR_W{1'b0}}, wr_push};
        g_d     = PtrW'(bin2gray(PTR_MAX_W'(b_d)));
        b_rq    = PtrW'(gray2bin(PTR_MAX_W'(rq)));
        level_d = b_d - b_rq;
        full_d  = (g_d == rq_full_pattern);
        af_d    = (level_d >= af_thresh);
        ovf_d   = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            b_q     <= '0;
            g_q     <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            b_q     <= b_d;
            g_q     <= g_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_addr     = b_q[ADDR_W-1:0];
    assign b_wr_ptr    = b_q;
    assign g_wr_ptr    = g_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Scoreboard bench for wr_ptr_ctrl: directed fill/overflow/release/wrap/reset plus random traffic.
// Expected state comes from an occupancy-count model with a delayed view of the read pointer.
module tb_wr_ptr_ctrl;

    localparam int DEPTH = 8;
    localparam int MOD   = 16;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_en;
    logic [3:0] g_rd_ptr_async;
    logic [3:0] af_thresh;
    logic       clr_ovf;
    logic       wr_push;
    logic [2:0] wr_addr;
    logic [3:0] b_wr_ptr;
    logic [3:0] g_wr_ptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    wr_ptr_ctrl #(
        .ADDR_W      (3),
        .SYNC_STAGES (2)
    ) dut (
        .wr_clk         (wr_clk),
        .wr_rst         (wr_rst),
        .wr_en          (wr_en),
        .g_rd_ptr_async (g_rd_ptr_async),
        .af_thresh      (af_thresh),
        .clr_ovf        (clr_ovf),
        .wr_push        (wr_push),
        .wr_addr        (wr_addr),
        .b_wr_ptr       (b_wr_ptr),
        .g_wr_ptr       (g_wr_ptr),
        .full           (full),
        .almost_full    (almost_full),
        .wr_level       (wr_level),
        .overflow       (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        int push;
        int b;
        int g;
        int full;
        int af;
        int lvl;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: write count, true read pointer, flags, read pointers seen at past edges.
    int m_w, m_rd, m_full, m_ovf;
    int rd_hist[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        m_w    = 0;
        m_rd   = 0;
        m_full = 0;
        m_ovf  = 0;
        rd_hist.delete();
        rd_hist.push_back(0);
        rd_hist.push_back(0);
    endtask

    // Drive one edge's worth of inputs and queue the state expected after that edge.
    task automatic cycle(input bit en, input bit clr, input int rd);
        exp_t e;
        int   r_seen, push, w_next, lvl;
        @(posedge wr_clk);
        #2;
        wr_en          = en;
        clr_ovf        = clr;
        g_rd_ptr_async = 4'(to_gray(rd));
        m_rd           = rd;
        r_seen = rd_hist[0];
        push   = (en && !m_full) ? 1 : 0;
        w_next = (m_w + push) % MOD;
        lvl    = (w_next - r_seen + MOD) % MOD;
        e.push = push;
        e.b    = w_next;
        e.g    = to_gray(w_next);
        e.lvl  = lvl;
        e.full = (lvl == DEPTH) ? 1 : 0;
        e.af   = (lvl >= int'(af_thresh)) ? 1 : 0;
        if (en && m_full)  e.ovf = 1;
        else if (clr)      e.ovf = 0;
        else               e.ovf = m_ovf;
        void'(rd_hist.pop_front());
        rd_hist.push_back(rd);
        m_w    = w_next;
        m_full = e.full;
        m_ovf  = e.ovf;
        exp_q.push_back(e);
    endtask

    task automatic flush();
        @(posedge wr_clk);
        #3;
    endtask

    task automatic do_reset();
        wr_rst         = 1'b1;
        wr_en          = 1'b0;
        clr_ovf        = 1'b0;
        g_rd_ptr_async = '0;
        model_reset();
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        wr_rst = 1'b0;
    endtask

    // Monitor: pop an expectation for each modelled edge and compare.
    initial begin
        exp_t e;
        int   p;
        forever begin
            @(negedge wr_clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                p = int'(wr_push);
                @(posedge wr_clk);
                #1;
                chk("wr_push", p, e.push);
                chk("b_wr_ptr", int'(b_wr_ptr), e.b);
                chk("g_wr_ptr", int'(g_wr_ptr), e.g);
                chk("wr_addr", int'(wr_addr), e.b % DEPTH);
                chk("full", int'(full), e.full);
                chk("almost_full", int'(almost_full), e.af);
                chk("wr_level", int'(wr_level), e.lvl);
                chk("overflow", int'(overflow), e.ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd, prev_b, prev_g, wrap_b, wrap_g;
        wr_rst         = 1'b1;
        wr_en          = 1'b0;
        clr_ovf        = 1'b0;
        g_rd_ptr_async = '0;
        af_thresh      = 4'd6;
        model_reset();
        #1;
        chk("reset_b_wr_ptr", int'(b_wr_ptr), 0);
        chk("reset_full", int'(full), 0);
        do_reset();

        // Fill: outputs seen after call k reflect edge k-1.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 0);
            if (i == 6) chk("fill_af_edge5", int'(almost_full), 0);
            if (i == 7) chk("fill_af_edge6", int'(almost_full), 1);
        end
        cycle(1'b1, 1'b0, 0);
        chk("fill_full", int'(full), 1);
        chk("fill_b", int'(b_wr_ptr), 8);
        chk("fill_g", int'(g_wr_ptr), 12);
        chk("fill_level", int'(wr_level), 8);
        chk("ovf_push_blocked", int'(wr_push), 0);
        cycle(1'b1, 1'b1, 0);
        chk("ovf_b_held", int'(b_wr_ptr), 8);
        chk("ovf_set", int'(overflow), 1);

        // Release: read pointer moves to 1; full drops on the third edge.
        cycle(1'b0, 1'b0, 1);
        chk("ovf_set_wins_clr", int'(overflow), 1);
        cycle(1'b0, 1'b0, 1);
        cycle(1'b0, 1'b0, 1);
        chk("release_full_edge2", int'(full), 1);
        cycle(1'b0, 1'b0, 1);
        chk("release_full_edge3", int'(full), 0);
        chk("release_level_edge3", int'(wr_level), 7);

        // Wrap: drain most entries, then write and read together across the pointer wrap.
        rd = 1;
        for (int i = 0; i < 6; i++) begin
            rd++;
            cycle(1'b0, 1'b0, rd);
        end
        wrap_b = 0;
        wrap_g = 0;
        for (int i = 0; i < 20; i++) begin
            if (((m_w - m_rd + MOD) % MOD) > 0) rd = (rd + 1) % MOD;
            prev_b = int'(b_wr_ptr);
            prev_g = int'(g_wr_ptr);
            cycle(1'b1, 1'b0, rd);
            if (prev_b == 15 && int'(b_wr_ptr) == 0) wrap_b = 1;
            if (prev_g == 8 && int'(g_wr_ptr) == 0) wrap_g = 1;
            chk("wrap_full_low", int'(full), 0);
        end
        chk("wrap_b_15_to_0", wrap_b, 1);
        chk("wrap_g_8_to_0", wrap_g, 1);

        // Reset mid-operation with level 5 and overflow set.
        flush();
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3);
        chk("pre_reset_level", int'(wr_level), 5);
        chk("pre_reset_ovf", int'(overflow), 1);
        flush();
        wr_rst = 1'b1;
        wr_en  = 1'b1;
        #1;
        chk("rst_wr_push", int'(wr_push), 0);
        chk("rst_b_wr_ptr", int'(b_wr_ptr), 0);
        chk("rst_g_wr_ptr", int'(g_wr_ptr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_wr_level", int'(wr_level), 0);
        chk("rst_overflow", int'(overflow), 0);
        do_reset();
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        chk("post_reset_first_write", int'(b_wr_ptr), 1);

        // Random traffic with a random threshold.
        flush();
        af_thresh = 4'($urandom_range(0, 8));
        do_reset();
        rd = 0;
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 2) == 1 && ((m_w - m_rd + MOD) % MOD) > 0) rd = (rd + 1) % MOD;
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, rd);
        end
        flush();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
